// File: rtl/titan_pkg.sv
// Shared definitions for the Titan fetch stage.
// Provides the NOP encoding, fetch exception cause codes, the fetch FSM state
// type, the fetch-buffer entry layout and small helpers that build entries.
package titan_pkg;

    localparam logic [31:0] TITAN_NOP           = 32'h0000_0033;
    localparam logic [3:0]  EXC_INST_MISALIGNED = 4'd0;
    localparam logic [3:0]  EXC_INST_ACCESS     = 4'd1;
    localparam logic [31:0] DEFAULT_RESET_ADDR  = 32'h8000_0000;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StHalt
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [3:0]  exc;
        logic [31:0] exc_data;
        logic        trap;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

    // Value presented downstream when nothing is available.
    function automatic fetch_entry_t bubble_entry();
        fetch_entry_t e;
        e.pc       = 32'h0;
        e.inst     = TITAN_NOP;
        e.exc      = 4'd0;
        e.exc_data = 32'h0;
        e.trap     = 1'b0;
        return e;
    endfunction

    function automatic fetch_entry_t inst_entry(input logic [31:0] pc, input logic [31:0] inst);
        fetch_entry_t e;
        e.pc       = pc;
        e.inst     = inst;
        e.exc      = 4'd0;
        e.exc_data = 32'h0;
        e.trap     = 1'b0;
        return e;
    endfunction

    // Faulting fetches carry a NOP and report the faulting pc as exc_data.
    function automatic fetch_entry_t trap_entry(input logic [31:0] pc, input logic [3:0] exc);
        fetch_entry_t e;
        e.pc       = pc;
        e.inst     = TITAN_NOP;
        e.exc      = exc;
        e.exc_data = pc;
        e.trap     = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/titan_fetch_buffer.sv
// Two-entry FIFO between the fetch logic and the IF/ID register.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   flush        - drop all entries (wins over push/pop)
//   push         - write push_entry at the tail
//   push_entry   - packed fetch_entry_t to write
//   pop          - drop the head entry
//   head_entry   - packed fetch_entry_t at the head (undefined when empty)
//   count        - number of valid entries (0..2)
module titan_fetch_buffer
    import titan_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [FETCH_ENTRY_W-1:0] push_entry,
    input  logic                     pop,
    output logic [FETCH_ENTRY_W-1:0] head_entry,
    output logic [1:0]               count
);

    fetch_entry_t mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    // Pop on empty is ignored; push on full is accepted only alongside a pop.
    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage needs no reset: the count qualifies every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= fetch_entry_t'(push_entry);
        end
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/titan_fetch_unit.sv
// Titan instruction fetch stage.
// Owns the program counter, issues one outstanding request at a time on the
// instruction-memory port and presents fetched entries to IF/ID from a
// two-entry buffer. An empty buffer presents a bubble (pc 0, NOP, no trap).
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   id_stall                  - IF/ID holding, head not consumed
//   pc_redirect_valid/_target - redirect request and new fetch address
//   imem_addr, imem_req       - request address/strobe, held until imem_ack
//   imem_ack, imem_data,
//   imem_err                  - response strobe, instruction word, access fault
//   if_pc, if_inst            - presented pc and instruction
//   if_exception, if_exc_data - exception cause and faulting address
//   if_trap_valid             - presented entry carries an exception
module titan_fetch_unit
    import titan_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall,
    input  logic        pc_redirect_valid,
    input  logic [31:0] pc_redirect_target,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        imem_err,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic [3:0]  if_exception,
    output logic [31:0] if_exc_data,
    output logic        if_trap_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         req_q, req_d;
    logic [31:0]  addr_q, addr_d;

    logic                     buf_flush;
    logic                     buf_push;
    logic                     buf_pop;
    fetch_entry_t             push_entry;
    logic [FETCH_ENTRY_W-1:0] buf_head;
    logic [1:0]               buf_count;
    logic [1:0]               occ_next;
    logic                     ack_fire;
    fetch_entry_t             head;

    assign ack_fire = req_q && imem_ack;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        buf_flush  = 1'b0;
        buf_pop    = 1'b0;
        buf_push   = 1'b0;
        push_entry = bubble_entry();
        occ_next   = buf_count;

        if (pc_redirect_valid) begin
            // Flush wins over consume and over any response arriving now.
            buf_flush = 1'b1;
            pc_d      = pc_redirect_target;
            if (req_q && !imem_ack) begin
                // Request still in flight: keep it up and discard its data later.
                state_d = StDrain;
            end else begin
                state_d = StRun;
                req_d   = 1'b0;
                if (pc_redirect_target[1:0] == 2'b00) begin
                    req_d  = 1'b1;
                    addr_d = pc_redirect_target;
                    pc_d   = pc_redirect_target + 32'd4;
                end
            end
        end else begin
            buf_pop = (buf_count != 2'd0) && !id_stall;
            unique case (state_q)
                StRun: begin
                    if (ack_fire) begin
                        req_d    = 1'b0;
                        buf_push = 1'b1;
                        if (imem_err) begin
                            push_entry = trap_entry(addr_q, EXC_INST_ACCESS);
                            state_d    = StHalt;
                        end else begin
                            push_entry = inst_entry(addr_q, imem_data);
                        end
                    end
                    // Issue only if a slot is guaranteed for the response.
                    occ_next = buf_count + {1'b0, buf_push} - {1'b0, buf_pop};
                    if ((state_d == StRun) && !req_d && (occ_next < 2'd2)) begin
                        if (pc_q[1:0] != 2'b00) begin
                            // Misaligned pc only follows a redirect, never an ack push.
                            if (!buf_push) begin
                                buf_push   = 1'b1;
                                push_entry = trap_entry(pc_q, EXC_INST_MISALIGNED);
                                state_d    = StHalt;
                            end
                        end else begin
                            req_d  = 1'b1;
                            addr_d = pc_q;
                            pc_d   = pc_q + 32'd4;
                        end
                    end
                end
                StDrain: begin
                    if (ack_fire) begin
                        req_d   = 1'b0;
                        state_d = StRun;
                    end
                end
                StHalt: begin
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            pc_q    <= RESET_ADDR;
            req_q   <= 1'b0;
            addr_q  <= RESET_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    titan_fetch_buffer u_fetch_buffer (
        .clk        (clk),
        .rst        (rst),
        .flush      (buf_flush),
        .push       (buf_push),
        .push_entry (push_entry),
        .pop        (buf_pop),
        .head_entry (buf_head),
        .count      (buf_count)
    );

    always_comb begin
        head = fetch_entry_t'(buf_head);
        if (buf_count == 2'd0) begin
            head = bubble_entry();
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = addr_q;
    assign if_pc         = head.pc;
    assign if_inst       = head.inst;
    assign if_exception  = head.exc;
    assign if_exc_data   = head.exc_data;
    assign if_trap_valid = head.trap;

endmodule

// File: tb/tb_titan_fetch_unit.sv
// Bench for titan_fetch_unit. The reference model is the program-order stream
// of entries expected to be consumed: sequential pcs from the last reset or
// redirect target, with data from a memory function, ending at the first trap.
module tb_titan_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [3:0]  exc;
        logic [31:0] exc_data;
        logic        trap;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        id_stall;
    logic        pc_redirect_valid;
    logic [31:0] pc_redirect_target;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        imem_err;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [3:0]  if_exception;
    logic [31:0] if_exc_data;
    logic        if_trap_valid;

    int          vectors;
    int          miscompares;
    int          consumed;
    int unsigned mem_min_lat;
    int unsigned mem_max_lat;
    logic [31:0] err_addr;
    bit          const_data;
    exp_t        exp_q[$];

    titan_fetch_unit #(
        .RESET_ADDR (32'h8000_0000)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .id_stall           (id_stall),
        .pc_redirect_valid  (pc_redirect_valid),
        .pc_redirect_target (pc_redirect_target),
        .imem_addr          (imem_addr),
        .imem_req           (imem_req),
        .imem_ack           (imem_ack),
        .imem_data          (imem_data),
        .imem_err           (imem_err),
        .if_pc              (if_pc),
        .if_inst            (if_inst),
        .if_exception       (if_exception),
        .if_exc_data        (if_exc_data),
        .if_trap_valid      (if_trap_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        if (const_data) return 32'h0000_0013;
        return {a[17:2], a[31:18]} ^ 32'h5A3C_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected consumed stream starting at a new fetch address.
    task automatic push_stream(input logic [31:0] start);
        exp_t        e;
        logic [31:0] a;
        exp_q.delete();
        if (start[1:0] != 2'b00) begin
            e = '{pc: start, inst: 32'h33, exc: 4'd0, exc_data: start, trap: 1'b1};
            exp_q.push_back(e);
            return;
        end
        for (int i = 0; i < 1024; i++) begin
            a = start + 32'(4 * i);
            if (a == err_addr) begin
                e = '{pc: a, inst: 32'h33, exc: 4'd1, exc_data: a, trap: 1'b1};
                exp_q.push_back(e);
                return;
            end
            e = '{pc: a, inst: inst_of(a), exc: 4'd0, exc_data: 32'h0, trap: 1'b0};
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_req(input int bound, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: imem_req got 0 for %0d cycles, expected 1", name, bound);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        repeat (3) tick();
        push_stream(32'h8000_0000);
        rst = 1'b0;
    endtask

    // Memory responder: random latency per request, data from inst_of().
    initial begin : responder
        bit          prev_req;
        bit          prev_ack;
        logic [31:0] prev_addr;
        int unsigned lat;
        int unsigned cnt;
        imem_ack  = 1'b0;
        imem_data = 32'h0;
        imem_err  = 1'b0;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_addr = 32'h0;
        lat       = 0;
        cnt       = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                imem_ack = 1'b0;
                imem_err = 1'b0;
                prev_req = 1'b0;
                prev_ack = 1'b0;
            end else begin
                if (imem_req) begin
                    if (!prev_req || prev_ack) begin
                        lat = $urandom_range(mem_max_lat, mem_min_lat);
                        cnt = 0;
                    end else begin
                        check("imem_addr_stable", imem_addr, prev_addr);
                    end
                    imem_ack  = (cnt >= lat);
                    cnt++;
                    imem_data = inst_of(imem_addr);
                    imem_err  = imem_ack && (imem_addr == err_addr);
                end else begin
                    imem_ack = 1'b0;
                    imem_err = 1'b0;
                end
                prev_req  = imem_req;
                prev_ack  = imem_ack;
                prev_addr = imem_addr;
            end
        end
    end

    // Monitor: every entry consumed by IF/ID is checked against the stream.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (if_pc != 32'h0) && !id_stall && !pc_redirect_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_entry: got pc %h, expected no entry", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", if_pc, e.pc);
                    check("sb_inst", if_inst, e.inst);
                    check("sb_exc", {28'h0, if_exception}, {28'h0, e.exc});
                    check("sb_exc_data", if_exc_data, e.exc_data);
                    check("sb_trap", {31'h0, if_trap_valid}, {31'h0, e.trap});
                    consumed++;
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] hold_pc;
        logic [31:0] old_addr;
        logic [31:0] t;
        int          consumed0;
        int          seen;

        vectors            = 0;
        miscompares        = 0;
        consumed           = 0;
        mem_min_lat        = 0;
        mem_max_lat        = 0;
        err_addr           = 32'h1;
        const_data         = 1'b1;
        rst                = 1'b1;
        id_stall           = 1'b0;
        pc_redirect_valid  = 1'b0;
        pc_redirect_target = 32'h0;

        // Reset state and zero-wait streaming.
        repeat (3) @(negedge clk);
        check("rst_imem_req", {31'h0, imem_req}, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h8000_0000);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_inst", if_inst, 32'h33);
        check("rst_if_exception", {28'h0, if_exception}, 32'h0);
        check("rst_if_exc_data", if_exc_data, 32'h0);
        check("rst_if_trap", {31'h0, if_trap_valid}, 32'h0);
        tick();
        push_stream(32'h8000_0000);
        rst = 1'b0;
        @(negedge clk);
        check("req_before_first_edge", {31'h0, imem_req}, 32'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("zw_req", {31'h0, imem_req}, 32'h1);
            check("zw_addr", imem_addr, 32'h8000_0000 + 32'(4 * k));
            if (k > 0) check("zw_if_pc", if_pc, 32'h8000_0000 + 32'(4 * (k - 1)));
        end

        // Five stalled cycles: buffer fills, no issue, outputs hold.
        tick();
        id_stall = 1'b1;
        hold_pc  = 32'h0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j == 0) begin
                hold_pc = if_pc;
            end else begin
                check("stall_req", {31'h0, imem_req}, 32'h0);
                check("stall_if_pc", if_pc, hold_pc);
            end
        end
        tick();
        id_stall = 1'b0;
        repeat (20) tick();

        // Randomised stalls, latencies and redirects.
        const_data  = 1'b0;
        mem_min_lat = 0;
        mem_max_lat = 3;
        do_reset();
        consumed0 = consumed;
        for (int i = 0; i < 600; i++) begin
            tick();
            id_stall          = ($urandom_range(9) < 3);
            pc_redirect_valid = 1'b0;
            if ($urandom_range(99) < 3) begin
                t = 32'h8000_0000 + ($urandom_range(16383) << 2);
                if ($urandom_range(9) == 0) t[1:0] = 2'b10;
                pc_redirect_target = t;
                pc_redirect_valid  = 1'b1;
                push_stream(t);
            end
        end
        tick();
        id_stall          = 1'b0;
        pc_redirect_valid = 1'b0;
        repeat (10) tick();
        check("random_progress", {31'h0, (consumed - consumed0) >= 50}, 32'h1);

        // Redirect while the request to 0x80000008 is outstanding (latency 3).
        mem_min_lat = 3;
        mem_max_lat = 3;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if (imem_req && !imem_ack && (imem_addr == 32'h8000_0008)) break;
            tick();
        end
        check("drain_setup_addr", imem_addr, 32'h8000_0008);
        old_addr           = imem_addr;
        pc_redirect_target = 32'h8000_0100;
        pc_redirect_valid  = 1'b1;
        push_stream(32'h8000_0100);
        tick();
        pc_redirect_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!(imem_req && (imem_addr == old_addr))) break;
            check("drain_bubble_pc", if_pc, 32'h0);
            tick();
        end
        tick();
        wait_req(10, "drain_refetch");
        check("drain_new_addr", imem_addr, 32'h8000_0100);
        repeat (30) tick();

        // Misaligned redirect traps and halts until the next redirect.
        mem_min_lat = 0;
        mem_max_lat = 0;
        repeat (10) tick();
        pc_redirect_target = 32'h8000_0102;
        pc_redirect_valid  = 1'b1;
        push_stream(32'h8000_0102);
        tick();
        pc_redirect_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            check("misal_no_req", {31'h0, imem_req}, 32'h0);
            if (if_trap_valid && (seen == 0)) begin
                seen = 1;
                check("misal_pc", if_pc, 32'h8000_0102);
                check("misal_exc", {28'h0, if_exception}, 32'h0);
                check("misal_exc_data", if_exc_data, 32'h8000_0102);
            end
            tick();
        end
        check("misal_trap_seen", seen, 1);
        pc_redirect_target = 32'h8000_0200;
        pc_redirect_valid  = 1'b1;
        push_stream(32'h8000_0200);
        tick();
        pc_redirect_valid = 1'b0;
        wait_req(5, "halt_resume");
        check("halt_resume_addr", imem_addr, 32'h8000_0200);
        repeat (20) tick();

        // Access fault on the fetch of 0x80000010.
        mem_min_lat = 0;
        mem_max_lat = 2;
        err_addr    = 32'h8000_0010;
        do_reset();
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (if_trap_valid) begin
                seen = 1;
                break;
            end
            tick();
        end
        check("err_trap_seen", seen, 1);
        check("err_exc", {28'h0, if_exception}, 32'h1);
        check("err_exc_data", if_exc_data, 32'h8000_0010);
        check("err_inst", if_inst, 32'h33);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("err_no_req", {31'h0, imem_req}, 32'h0);
        end
        err_addr = 32'h1;

        // Reset in the middle of an outstanding request.
        mem_min_lat = 3;
        mem_max_lat = 3;
        do_reset();
        tick();
        wait_req(5, "rst_mid_setup");
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("rst_mid_req", {31'h0, imem_req}, 32'h0);
        check("rst_mid_if_pc", if_pc, 32'h0);
        check("rst_mid_if_inst", if_inst, 32'h33);
        check("rst_mid_if_trap", {31'h0, if_trap_valid}, 32'h0);
        tick();
        tick();
        push_stream(32'h8000_0000);
        rst = 1'b0;
        wait_req(5, "rst_mid_refetch");
        check("rst_mid_refetch_addr", imem_addr, 32'h8000_0000);
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/titan_fetch_unit.md
# titan_fetch_unit

Instruction fetch stage of the Titan pipeline: owns the program counter, issues single-outstanding requests on the instruction-memory port, and presents fetched instructions with their PC and fetch-exception info to the IF/ID pipeline register. Honours back-pressure (`id_stall`) and redirects (branch/jump/trap targets). When no instruction is available it presents a bubble: PC 0, NOP `32'h33`, no exception.

## Interface
- `RESET_ADDR`, default `32'h8000_0000`: first fetch address after reset.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `id_stall`  in  1  IF/ID holding; presented entry not consumed this edge.
- `pc_redirect_valid`  in  1  redirect request (branch taken, jump, trap entry, xRET).
- `pc_redirect_target`  in  32  new fetch address.
- `imem_addr`  out  32  request address; stable while `imem_req` high.
- `imem_req`  out  1  request strobe; held until `imem_ack`.
- `imem_ack`  in  1  response valid; only legal while `imem_req` high.
- `imem_data`  in  32  instruction word, valid with `imem_ack`.
- `imem_err`  in  1  access fault, qualified by `imem_ack`.
- `if_pc`, `if_inst`  out  32  presented PC / instruction.
- `if_exception`  out  4  exception cause code.
- `if_exc_data`  out  32  faulting address.
- `if_trap_valid`  out  1  presented entry carries an exception.

## Operation
- Internal 2-entry fetch buffer. Outputs are driven combinationally from the head entry; when the buffer is empty they are the bubble values.
- Consume: on an edge with buffer non-empty, `!id_stall`, `!pc_redirect_valid`, the head pops.
- Issue condition: state RUN, no outstanding request, (occupancy after this edge's pop/push) < 2. On issue: `imem_req` rises after the edge, `imem_addr`=pc, pc += 4. Wrap from `32'hFFFF_FFFC` to `0` is silent.
- On ack (not discarded): push {pc of request, `imem_data`, exc 0, trap 0}. If `imem_err`, push {pc, `32'h33`, `EXC_INST_ACCESS`=4'd1, exc_data=pc, trap 1} instead, then go to HALT.
- Misaligned pc (`pc[1:0]!=0`) at issue: no memory request; push {pc, `32'h33`, `EXC_INST_MISALIGNED`=4'd0, exc_data=pc, trap 1}, then go to HALT.
- States:
  - RUN: normal fetch.
  - DRAIN: a redirect arrived with a request outstanding. Keep `imem_req` high until ack, discard the data, then go to RUN at the target.
  - HALT: no requests. Leaves only on redirect.
- Redirect, any state: buffer flushed the same edge, pc=target. Then:
  - outstanding request not acked this cycle → DRAIN;
  - otherwise → RUN, and issue at the target on that edge if aligned.
- Priority: `rst` > redirect > consume/push.

## Timing
- Reset values: state RUN, pc=`RESET_ADDR`, buffer empty, `imem_req`=0, `imem_addr`=`RESET_ADDR`. Outputs show the bubble: `if_pc`=0, `if_inst`=`32'h33`, `if_exception`=0, `if_exc_data`=0, `if_trap_valid`=0.
- First `imem_req` is asserted after the first edge following `rst` deassertion.
- Latency: ack in cycle N → entry visible at outputs in cycle N+1 → consumed at the end of N+1 if not stalled.
- Zero-wait memory (ack in the request cycle) sustains 1 instruction/cycle.
- Stall with a full buffer: no new issue. An outstanding ack always has a free slot, by the issue rule.
- Redirect and ack in the same cycle: ack data dropped, no DRAIN.
- Redirect and consume in the same edge: flush wins.
- `rst` mid-request: `imem_req` drops asynchronously; the memory side must tolerate an abandoned request.

## Structure
- Shared package `titan_pkg`: `TITAN_NOP`=`32'h33`, `EXC_INST_MISALIGNED`, `EXC_INST_ACCESS`, fetch-state enum, default `RESET_ADDR`.
- Sub-module `titan_fetch_buffer`: 2-entry FIFO of {pc, inst, exc, exc_data, trap} with push, pop, flush, count.

## Test plan
- Reset release, zero-wait memory returning `32'h00000013` → `imem_addr` 0x80000000, 0x80000004, …, one per cycle; `if_pc` follows one cycle after each ack; `if_inst`=0x13.
- Hold `id_stall`=1 for 5 cycles → at most 2 buffered, `imem_req` stays low, outputs constant; after release, the entries drain in order with no PC gap.
- Redirect to 0x80000100 while a request to 0x80000008 is outstanding with 3-cycle latency → DRAIN, that response discarded, next `imem_addr`=0x80000100, bubble presented meanwhile.
- Redirect to 0x80000102 → no request; presented entry `if_pc`=0x80000102, `if_exception`=0, `if_exc_data`=0x80000102, `if_trap_valid`=1; HALT until redirect to 0x80000200 resumes fetch.
- `imem_err` on the ack for 0x80000010 → entry with `if_exception`=1, `if_exc_data`=0x80000010, `if_inst`=0x33; no further requests.
- Assert `rst` while `imem_req` is high → `imem_req` drops immediately, outputs show the bubble, refetch from 0x80000000.
